// File: rtl/ysyx_22050854_axi_pkg.sv
// Shared definitions for the IFU/LSU AXI arbiter: FSM encodings and default IDs.
package ysyx_22050854_axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } w_state_e;

    localparam logic [3:0] IFU_ID_DEFAULT = 4'd0;
    localparam logic [3:0] LSU_ID_DEFAULT = 4'd1;

    // Grant vector bit positions
    localparam int unsigned GNT_IFU = 0;
    localparam int unsigned GNT_LSU = 1;

endpackage

// File: rtl/ysyx_22050854_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advanced on a done pulse.
module ysyx_22050854_rr_arb2
    import ysyx_22050854_axi_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    output logic [1:0] gnt
);

    // last_q holds the index of the most recent winner
    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= 1'b0;
        end else if (done) begin
            last_q <= gnt[GNT_LSU];
        end
    end

endmodule

// File: rtl/ysyx_22050854_axi_arbiter.sv
// Arbitrates IFU and LSU reads onto one AXI4 master port; LSU writes pass through
// an independent write FSM.
module ysyx_22050854_axi_arbiter
    import ysyx_22050854_axi_pkg::*;
#(
    parameter logic [3:0] IFU_ID = IFU_ID_DEFAULT,
    parameter logic [3:0] LSU_ID = LSU_ID_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_arvalid,
    input  logic [31:0] ifu_araddr,
    input  logic [7:0]  ifu_arlen,
    input  logic [2:0]  ifu_arsize,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_arready,
    output logic        ifu_rvalid,
    output logic [63:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    input  logic        ifu_rready,
    input  logic        lsu_arvalid,
    input  logic [31:0] lsu_araddr,
    input  logic [7:0]  lsu_arlen,
    input  logic [2:0]  lsu_arsize,
    input  logic [1:0]  lsu_arburst,
    output logic        lsu_arready,
    output logic        lsu_rvalid,
    output logic [63:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rlast,
    input  logic        lsu_rready,
    input  logic        lsu_awvalid,
    input  logic [31:0] lsu_awaddr,
    input  logic [7:0]  lsu_awlen,
    input  logic [2:0]  lsu_awsize,
    input  logic [1:0]  lsu_awburst,
    output logic        lsu_awready,
    input  logic        lsu_wvalid,
    input  logic [63:0] lsu_wdata,
    input  logic [7:0]  lsu_wstrb,
    input  logic        lsu_wlast,
    output logic        lsu_wready,
    output logic        lsu_bvalid,
    output logic [1:0]  lsu_bresp,
    input  logic        lsu_bready,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        wvalid,
    input  logic        wready,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    input  logic        bvalid,
    output logic        bready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp
);

    r_state_e   r_state_q;
    w_state_e   w_state_q;
    logic       sel_lsu_q;
    logic       err_q;
    logic [1:0] rr_req;
    logic [1:0] rr_gnt;
    logic       rr_done;
    logic [3:0] cur_id;
    logic       r_addr, r_data;
    logic       w_addr, w_data, w_resp;

    assign rr_req  = {lsu_arvalid, ifu_arvalid};
    assign rr_done = !reset && (r_state_q == R_IDLE) && (|rr_req);
    assign cur_id  = sel_lsu_q ? LSU_ID : IFU_ID;

    ysyx_22050854_rr_arb2 u_rr_arb2 (
        .clock (clock),
        .reset (reset),
        .req   (rr_req),
        .done  (rr_done),
        .gnt   (rr_gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            sel_lsu_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (r_state_q)
                R_IDLE: if (rr_done) begin
                    sel_lsu_q <= rr_gnt[GNT_LSU];
                    r_state_q <= R_ADDR;
                end
                R_ADDR: if (arready) r_state_q <= R_DATA;
                R_DATA: begin
                    if (rvalid && (rid != cur_id)) err_q <= 1'b1;
                    if (rvalid && rready && rlast) r_state_q <= R_IDLE;
                end
                default: r_state_q <= R_IDLE;
            endcase
            // Response IDs on B are also tracked so a misrouted write response is visible
            if ((w_state_q == W_RESP) && bvalid && (bid != LSU_ID)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= W_IDLE;
        end else begin
            unique case (w_state_q)
                W_IDLE: if (lsu_awvalid) w_state_q <= W_ADDR;
                W_ADDR: if (lsu_awvalid && awready) w_state_q <= W_DATA;
                W_DATA: if (lsu_wvalid && wready && lsu_wlast) w_state_q <= W_RESP;
                W_RESP: if (bvalid && lsu_bready) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Handshake qualifiers are forced low while reset is held
    assign r_addr = !reset && (r_state_q == R_ADDR);
    assign r_data = !reset && (r_state_q == R_DATA);
    assign w_addr = !reset && (w_state_q == W_ADDR);
    assign w_data = !reset && (w_state_q == W_DATA);
    assign w_resp = !reset && (w_state_q == W_RESP);

    assign arvalid     = r_addr;
    assign arid        = cur_id;
    assign araddr      = sel_lsu_q ? lsu_araddr  : ifu_araddr;
    assign arlen       = sel_lsu_q ? lsu_arlen   : ifu_arlen;
    assign arsize      = sel_lsu_q ? lsu_arsize  : ifu_arsize;
    assign arburst     = sel_lsu_q ? lsu_arburst : ifu_arburst;
    assign ifu_arready = r_addr && !sel_lsu_q && arready;
    assign lsu_arready = r_addr && sel_lsu_q && arready;

    assign rready     = r_data && (sel_lsu_q ? lsu_rready : ifu_rready);
    assign ifu_rvalid = r_data && !sel_lsu_q && rvalid;
    assign lsu_rvalid = r_data && sel_lsu_q && rvalid;
    assign ifu_rdata  = rdata;
    assign lsu_rdata  = rdata;
    assign ifu_rresp  = rresp;
    assign lsu_rresp  = rresp;
    assign ifu_rlast  = rlast;
    assign lsu_rlast  = rlast;

    assign awvalid     = w_addr && lsu_awvalid;
    assign awid        = LSU_ID;
    assign awaddr      = lsu_awaddr;
    assign awlen       = lsu_awlen;
    assign awsize      = lsu_awsize;
    assign awburst     = lsu_awburst;
    assign lsu_awready = w_addr && awready;

    assign wvalid     = w_data && lsu_wvalid;
    assign wdata      = lsu_wdata;
    assign wstrb      = lsu_wstrb;
    assign wlast      = lsu_wlast;
    assign lsu_wready = w_data && wready;

    assign lsu_bvalid = w_resp && bvalid;
    assign lsu_bresp  = bresp;
    assign bready     = w_resp && lsu_bready;

endmodule

// File: tb/tb_ysyx_22050854_axi_arbiter.sv
// Directed bench: bench acts as IFU, LSU and the downstream AXI slave.
module tb_ysyx_22050854_axi_arbiter;

    localparam logic [3:0] IFU_ID = 4'd0;
    localparam logic [3:0] LSU_ID = 4'd1;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rlast, ifu_rready;
    logic [31:0] ifu_araddr;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst, ifu_rresp;
    logic [63:0] ifu_rdata;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rlast, lsu_rready;
    logic [31:0] lsu_araddr;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst, lsu_rresp;
    logic [63:0] lsu_rdata;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wlast, lsu_wready;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr;
    logic [7:0]  lsu_awlen, lsu_wstrb;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst, lsu_bresp;
    logic [63:0] lsu_wdata;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, rresp, awburst, bresp;
    logic [63:0] rdata, wdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;

    int checks = 0;
    int errors = 0;
    int ifu_beats = 0;
    int lsu_beats = 0;
    int b_count = 0;

    always #5 clock = ~clock;

    ysyx_22050854_axi_arbiter #(.IFU_ID(IFU_ID), .LSU_ID(LSU_ID)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
        .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst), .ifu_arready(ifu_arready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
        .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst), .lsu_arready(lsu_arready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen),
        .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst), .lsu_awready(lsu_awready),
        .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
    );

    always @(posedge clock) begin
        if (ifu_rvalid && ifu_rready) ifu_beats <= ifu_beats + 1;
        if (lsu_rvalid && lsu_rready) lsu_beats <= lsu_beats + 1;
        if (lsu_bvalid && lsu_bready) b_count <= b_count + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req_read(input bit is_lsu, input logic [31:0] addr, input logic [7:0] len);
        if (is_lsu) begin
            lsu_arvalid = 1'b1; lsu_araddr = addr; lsu_arlen = len;
        end else begin
            ifu_arvalid = 1'b1; ifu_araddr = addr; ifu_arlen = len;
        end
    endtask

    // Slave side of one read: expects a grant to the requester owning `id`.
    task automatic serve_read(input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input int stall_at, input bit bad_rid);
        int w;
        int b0;
        bit is_lsu;
        logic [63:0] d;
        is_lsu = (id == LSU_ID);
        b0 = is_lsu ? lsu_beats : ifu_beats;
        w = 0;
        #1;
        while (arvalid !== 1'b1 && w < 20) begin
            tick();
            #1;
            w++;
        end
        chk("ar_gap", 64'(w), 64'd1);
        chk("arid", 64'(arid), 64'(id));
        chk("araddr", 64'(araddr), 64'(addr));
        chk("arlen", 64'(arlen), 64'(len));
        chk("arsize", 64'(arsize), 64'd3);
        arready = 1'b1;
        #1;
        chk("arready_grant", 64'(is_lsu ? lsu_arready : ifu_arready), 64'd1);
        chk("arready_other", 64'(is_lsu ? ifu_arready : lsu_arready), 64'd0);
        tick();
        arready = 1'b0;
        if (is_lsu) lsu_arvalid = 1'b0;
        else ifu_arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            d = {addr, 32'(b)} ^ 64'h5a5a_0000_c3c3_0000;
            rvalid = 1'b1;
            rdata = d;
            rid = (bad_rid && b == 0) ? ~id : id;
            rresp = 2'b00;
            rlast = (b == int'(len));
            if (b == stall_at) begin
                if (is_lsu) lsu_rready = 1'b0;
                else ifu_rready = 1'b0;
                #1;
                chk("rready_stall", 64'(rready), 64'd0);
                repeat (3) begin
                    tick();
                    #1;
                    chk("hold_valid", 64'(is_lsu ? lsu_rvalid : ifu_rvalid), 64'd1);
                    chk("hold_data", is_lsu ? lsu_rdata : ifu_rdata, d);
                end
                if (is_lsu) lsu_rready = 1'b1;
                else ifu_rready = 1'b1;
            end
            #1;
            chk("rvalid_grant", 64'(is_lsu ? lsu_rvalid : ifu_rvalid), 64'd1);
            chk("rvalid_other", 64'(is_lsu ? ifu_rvalid : lsu_rvalid), 64'd0);
            chk("rdata", is_lsu ? lsu_rdata : ifu_rdata, d);
            chk("rlast", 64'(is_lsu ? lsu_rlast : ifu_rlast), 64'(b == int'(len)));
            chk("rready", 64'(rready), 64'd1);
            tick();
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        chk("beat_count", 64'((is_lsu ? lsu_beats : ifu_beats) - b0), 64'(int'(len) + 1));
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len);
        int w;
        int b0;
        lsu_awvalid = 1'b1;
        lsu_awaddr = addr;
        lsu_awlen = len;
        w = 0;
        #1;
        while (awvalid !== 1'b1 && w < 20) begin
            tick();
            #1;
            w++;
        end
        chk("awvalid", 64'(awvalid), 64'd1);
        chk("awid", 64'(awid), 64'(LSU_ID));
        chk("awaddr", 64'(awaddr), 64'(addr));
        awready = 1'b1;
        #1;
        chk("lsu_awready", 64'(lsu_awready), 64'd1);
        tick();
        awready = 1'b0;
        lsu_awvalid = 1'b0;
        wready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            lsu_wvalid = 1'b1;
            lsu_wdata = {addr, 32'(i)} | 64'h00a5;
            lsu_wlast = (i == int'(len));
            #1;
            chk("wvalid", 64'(wvalid), 64'd1);
            chk("wdata", wdata, {addr, 32'(i)} | 64'h00a5);
            chk("lsu_wready", 64'(lsu_wready), 64'd1);
            tick();
        end
        lsu_wvalid = 1'b0;
        lsu_wlast = 1'b0;
        wready = 1'b0;
        b0 = b_count;
        bvalid = 1'b1;
        bid = LSU_ID;
        bresp = 2'b00;
        #1;
        chk("lsu_bvalid", 64'(lsu_bvalid), 64'd1);
        tick();
        bvalid = 1'b0;
        repeat (3) begin
            #1;
            chk("bvalid_after", 64'(lsu_bvalid), 64'd0);
            tick();
        end
        chk("b_once", 64'(b_count - b0), 64'd1);
    endtask

    typedef struct {
        bit          ifu_req;
        bit          lsu_req;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        int          n;
        logic [3:0]  id0;
        logic [31:0] addr0;
        logic [3:0]  id1;
        logic [31:0] addr1;
    } rd_vec_t;

    rd_vec_t vecs[6];

    initial begin
        vecs[0] = '{1, 1, 32'h8000_0100, 32'h8000_2100, 2, LSU_ID, 32'h8000_2100,
                    IFU_ID, 32'h8000_0100};
        vecs[1] = '{1, 1, 32'h8000_0200, 32'h8000_2200, 2, LSU_ID, 32'h8000_2200,
                    IFU_ID, 32'h8000_0200};
        vecs[2] = '{0, 1, 32'h0, 32'h8000_2300, 1, LSU_ID, 32'h8000_2300, IFU_ID, 32'h0};
        vecs[3] = '{1, 1, 32'h8000_0400, 32'h8000_2400, 2, IFU_ID, 32'h8000_0400,
                    LSU_ID, 32'h8000_2400};
        vecs[4] = '{1, 0, 32'h8000_0500, 32'h0, 1, IFU_ID, 32'h8000_0500, IFU_ID, 32'h0};
        vecs[5] = '{1, 0, 32'h8000_0000, 32'h0, 1, IFU_ID, 32'h8000_0000, IFU_ID, 32'h0};

        reset = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h0; ifu_arlen = 8'd1; ifu_arsize = 3'd3;
        ifu_arburst = 2'b01; ifu_rready = 1'b1;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0; lsu_arlen = 8'd1; lsu_arsize = 3'd3;
        lsu_arburst = 2'b01; lsu_rready = 1'b1;
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h0; lsu_awlen = 8'd1; lsu_awsize = 3'd3;
        lsu_awburst = 2'b01; lsu_wvalid = 1'b1; lsu_wdata = 64'h0; lsu_wstrb = 8'hff;
        lsu_wlast = 1'b0; lsu_bready = 1'b1;
        arready = 1'b1; rvalid = 1'b1; rid = 4'd0; rdata = 64'h0; rresp = 2'b00;
        rlast = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bid = LSU_ID;
        bresp = 2'b00;

        // Valids/readies must stay low while reset is held, even with every input active
        tick();
        tick();
        #1;
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_ifu_arready", 64'(ifu_arready), 64'd0);
        chk("rst_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
        chk("rst_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_lsu_bvalid", 64'(lsu_bvalid), 64'd0);
        chk("rst_err", 64'(dut.err_q), 64'd0);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // First tie after reset goes to LSU; IFU follows after one idle cycle
        req_read(1'b0, 32'h8000_0040, 8'd1);
        req_read(1'b1, 32'h8000_2040, 8'd1);
        serve_read(LSU_ID, 32'h8000_2040, 8'd1, -1, 1'b0);
        serve_read(IFU_ID, 32'h8000_0040, 8'd1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].ifu_req) req_read(1'b0, vecs[i].ifu_addr, 8'd1);
            if (vecs[i].lsu_req) req_read(1'b1, vecs[i].lsu_addr, 8'd1);
            serve_read(vecs[i].id0, vecs[i].addr0, 8'd1, -1, 1'b0);
            if (vecs[i].n == 2) serve_read(vecs[i].id1, vecs[i].addr1, 8'd1, -1, 1'b0);
        end

        // Requester stalls rready for 3 cycles on the second beat of a 4-beat burst
        req_read(1'b0, 32'h8000_0600, 8'd3);
        serve_read(IFU_ID, 32'h8000_0600, 8'd3, 1, 1'b0);

        // LSU write runs concurrently with an IFU read
        req_read(1'b0, 32'h8000_0700, 8'd1);
        fork
            serve_read(IFU_ID, 32'h8000_0700, 8'd1, -1, 1'b0);
            do_write(32'h8000_1000, 8'd1);
        join
        chk("err_clean", 64'(dut.err_q), 64'd0);

        // Wrong rid on first beat: routed unchanged, sticky error set
        req_read(1'b0, 32'h8000_0800, 8'd1);
        serve_read(IFU_ID, 32'h8000_0800, 8'd1, -1, 1'b1);
        chk("err_set", 64'(dut.err_q), 64'd1);

        // Reset during R_DATA abandons the burst
        req_read(1'b0, 32'h8000_0900, 8'd1);
        serve_read_prefix: begin
            int w;
            w = 0;
            #1;
            while (arvalid !== 1'b1 && w < 20) begin
                tick();
                #1;
                w++;
            end
            chk("mid_arvalid", 64'(arvalid), 64'd1);
            arready = 1'b1;
            tick();
            arready = 1'b0;
            ifu_arvalid = 1'b0;
        end
        ifu_rready = 1'b0;
        rvalid = 1'b1; rid = IFU_ID; rdata = 64'h1234; rlast = 1'b0;
        #1;
        chk("mid_rvalid", 64'(ifu_rvalid), 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_rvalid", 64'(ifu_rvalid), 64'd0);
        chk("mid_rst_rready", 64'(rready), 64'd0);
        tick();
        reset = 1'b0;
        rvalid = 1'b0;
        ifu_rready = 1'b1;
        #1;
        chk("post_rst_rvalid", 64'(ifu_rvalid), 64'd0);
        chk("post_rst_arvalid", 64'(arvalid), 64'd0);
        chk("post_rst_err", 64'(dut.err_q), 64'd0);
        tick();
        // Pointer was reset, so the next tie again favours LSU
        req_read(1'b0, 32'h8000_0a00, 8'd1);
        req_read(1'b1, 32'h8000_2a00, 8'd1);
        serve_read(LSU_ID, 32'h8000_2a00, 8'd1, -1, 1'b0);
        serve_read(IFU_ID, 32'h8000_0a00, 8'd1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
